fifo_wr_arbiter: RTL and testbench

// Shares the write port of one fifo instance among NREQ requesters. Round-robin

---
 rtl/fifo_wr_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Write-port arbiter for a single fifo: round-robin grant per word with optional burst lock.
// Grants are combinational so that a word reaches the fifo in the same cycle it is granted.

module fifo_wr_arbiter_chk #(
    parameter int NREQ = 4
) (
    input logic            clk,
    input logic            rst,
    input logic [NREQ-1:0] req,
    input logic [NREQ-1:0] gnt,
    input logic            fifo_w,
    input logic            fifo_full
);

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_w_matches_gnt : assert property (@(posedge clk) disable iff (rst) fifo_w == (|gnt));
    a_gnt_needs_req : assert property (@(posedge clk) disable iff (rst) (gnt & ~req) == '0);
    a_full_blocks : assert property (@(posedge clk) disable iff (rst) fifo_full |-> (gnt == '0));

endmodule

module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8,
    localparam int IDX_W    = $clog2(NREQ),
    localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*WIDTH-1:0] din,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      fifo_din,
    output logic                  fifo_w,
    input  logic                  fifo_full,
    output logic                  locked,
    output logic [IDX_W-1:0]      owner
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   prio_r;
    logic [IDX_W-1:0]   prio_s;
    logic [IDX_W-1:0]   owner_r;
    logic [IDX_W-1:0]   owner_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic [NREQ-1:0]    gnt_s;
    logic [WIDTH-1:0]   fifo_din_s;
    logic [IDX_W-1:0]   scan_idx_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic               win_found_s;

    // (base + k) mod NREQ without relying on NREQ being a power of two
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) begin
            s = s - NREQ;
        end else begin
            s = s;
        end
        return IDX_W'(s);
    endfunction

    // Round-robin scan starting at the current priority index
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        scan_idx_s  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx_s = wrap_add(prio_r, k);
            if (!win_found_s && req[scan_idx_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = scan_idx_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Grant selection and next-state logic for the IDLE/LOCKED machine
    always_comb begin
        state_s   = state_r;
        prio_s    = prio_r;
        owner_s   = owner_r;
        cnt_s     = cnt_r;
        gnt_s     = '0;
        cnt_inc_s = cnt_r + CNT_W'(1);
        if (rst || fifo_full) begin
            gnt_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        gnt_s[win_idx_s] = 1'b1;
                        if (lock[win_idx_s] && (MAX_BURST > 1)) begin
                            state_s = ST_LOCKED;
                            owner_s = win_idx_s;
                            cnt_s   = CNT_W'(1);
                        end else begin
                            prio_s = wrap_add(win_idx_s, 1);
                        end
                    end else begin
                        gnt_s = '0;
                    end
                end
                ST_LOCKED: begin
                    if (req[owner_r]) begin
                        gnt_s[owner_r] = 1'b1;
                        if (!lock[owner_r] || (cnt_inc_s == CNT_W'(MAX_BURST))) begin
                            state_s = ST_IDLE;
                            prio_s  = wrap_add(owner_r, 1);
                            owner_s = '0;
                            cnt_s   = '0;
                        end else begin
                            cnt_s = cnt_inc_s;
                        end
                    end else if (!lock[owner_r]) begin
                        // owner went quiet and gave up the lock: release without a transfer
                        state_s = ST_IDLE;
                        prio_s  = wrap_add(owner_r, 1);
                        owner_s = '0;
                        cnt_s   = '0;
                    end else begin
                        gnt_s = '0;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    prio_s  = '0;
                    owner_s = '0;
                    cnt_s   = '0;
                    gnt_s   = '0;
                end
            endcase
        end
    end

    // Data mux from the granted requester slice to the fifo
    always_comb begin
        fifo_din_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_s[i]) begin
                fifo_din_s = din[i*WIDTH +: WIDTH];
            end else begin
                fifo_din_s = fifo_din_s;
            end
        end
    end

    // Arbitration state registers; a full fifo freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            prio_r  <= '0;
            owner_r <= '0;
            cnt_r   <= '0;
        end else if (!fifo_full) begin
            state_r <= state_s;
            prio_r  <= prio_s;
            owner_r <= owner_s;
            cnt_r   <= cnt_s;
        end else begin
            state_r <= state_r;
            prio_r  <= prio_r;
            owner_r <= owner_r;
            cnt_r   <= cnt_r;
        end
    end

    assign gnt      = gnt_s;
    assign fifo_w   = |gnt_s;
    assign fifo_din = fifo_din_s;
    assign locked   = (state_r == ST_LOCKED) && !rst;
    assign owner    = rst ? '0 : owner_r;

    fifo_wr_arbiter_chk #(
        .NREQ (NREQ)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .fifo_w    (fifo_w),
        .fifo_full (fifo_full)
    );

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: round-robin order, burst lock, full stalls and reset.

module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic [7:0]  fifo_din;
    logic        fifo_w;
    logic        fifo_full;
    logic        locked;
    logic [1:0]  owner;

    int tests;
    int fails;

    fifo_wr_arbiter #(
        .WIDTH     (8),
        .NREQ      (4),
        .MAX_BURST (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .din       (din),
        .gnt       (gnt),
        .fifo_din  (fifo_din),
        .fifo_w    (fifo_w),
        .fifo_full (fifo_full),
        .locked    (locked),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_din(input logic [3:0] g);
        case (g)
            4'b0001: return din[7:0];
            4'b0010: return din[15:8];
            4'b0100: return din[23:16];
            4'b1000: return din[31:24];
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check the combinational and registered outputs, then clock.
    task automatic step(input string tag, input logic rs, input logic [3:0] r, input logic [3:0] l,
                        input logic f, input logic [3:0] eg, input logic el, input logic [1:0] eo);
        rst       = rs;
        req       = r;
        lock      = l;
        fifo_full = f;
        #2;
        check({tag, ".gnt"}, 32'(gnt), 32'(eg));
        check({tag, ".fifo_w"}, 32'(fifo_w), 32'(|eg));
        check({tag, ".fifo_din"}, 32'(fifo_din), 32'(exp_din(eg)));
        check({tag, ".locked"}, 32'(locked), 32'(el));
        check({tag, ".owner"}, 32'(owner), 32'(eo));
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        req       = 4'b0000;
        lock      = 4'b0000;
        fifo_full = 1'b0;
        din       = 32'h44332211;

        // reset holds all outputs low even with every requester active
        step("rst0", 1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);
        step("rst1", 1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);

        // 1: full round robin
        step("t1.c0", 1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd0);
        din = 32'hD4C3B2A1;
        step("t1.c1", 1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd0);
        step("t1.c2", 1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd0);
        step("t1.c3", 1'b0, 4'b1111, 4'b0000, 1'b0, 4'b1000, 1'b0, 2'd0);
        step("t1.c4", 1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd0);

        // 2: sparse requests, prio is now 1
        step("t2.c0", 1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd0);
        step("t2.c1", 1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd0);
        step("t2.c2", 1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd0);
        step("t2.c3", 1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd0);
        step("t2.none", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);

        // 3: max-length burst by requester 1
        step("t3.rst", 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);
        step("t3.c0", 1'b0, 4'b1111, 4'b0010, 1'b0, 4'b0001, 1'b0, 2'd0);
        step("t3.w1", 1'b0, 4'b1111, 4'b0010, 1'b0, 4'b0010, 1'b0, 2'd0);
        for (int w = 2; w <= 8; w++) begin
            step($sformatf("t3.w%0d", w), 1'b0, 4'b1111, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1);
        end
        step("t3.after", 1'b0, 4'b1111, 4'b0010, 1'b0, 4'b0100, 1'b0, 2'd0);

        // 4: fifo full stalls burst word 4 for three cycles
        step("t4.rst", 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);
        step("t4.c0", 1'b0, 4'b1111, 4'b0010, 1'b0, 4'b0001, 1'b0, 2'd0);
        step("t4.w1", 1'b0, 4'b1111, 4'b0010, 1'b0, 4'b0010, 1'b0, 2'd0);
        step("t4.w2", 1'b0, 4'b1111, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1);
        step("t4.w3", 1'b0, 4'b1111, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1);
        for (int s = 0; s < 3; s++) begin
            step($sformatf("t4.full%0d", s), 1'b0, 4'b1111, 4'b0010, 1'b1, 4'b0000, 1'b1, 2'd1);
        end
        for (int w = 4; w <= 8; w++) begin
            step($sformatf("t4.w%0d", w), 1'b0, 4'b1111, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1);
        end
        step("t4.after", 1'b0, 4'b1111, 4'b0010, 1'b0, 4'b0100, 1'b0, 2'd0);

        // 5: requester 2 drops lock with its third word
        step("t5.rst", 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);
        step("t5.c0", 1'b0, 4'b1111, 4'b0100, 1'b0, 4'b0001, 1'b0, 2'd0);
        step("t5.c1", 1'b0, 4'b1111, 4'b0100, 1'b0, 4'b0010, 1'b0, 2'd0);
        step("t5.w1", 1'b0, 4'b1111, 4'b0100, 1'b0, 4'b0100, 1'b0, 2'd0);
        step("t5.w2", 1'b0, 4'b1111, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2);
        step("t5.w3", 1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2);
        step("t5.after", 1'b0, 4'b1111, 4'b0000, 1'b0, 4'b1000, 1'b0, 2'd0);

        // 6: owner 3 idles while holding lock, then reset drops the burst
        step("t6.w1", 1'b0, 4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b0, 2'd0);
        step("t6.w2", 1'b0, 4'b1111, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3);
        step("t6.hold", 1'b0, 4'b0111, 4'b1000, 1'b0, 4'b0000, 1'b1, 2'd3);
        step("t6.rst", 1'b1, 4'b1111, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd0);
        step("t6.next", 1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd0);

        // release without transfer when owner drops both req and lock
        step("t7.w1", 1'b0, 4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0);
        step("t7.rel", 1'b0, 4'b0110, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0);
        step("t7.next", 1'b0, 4'b0110, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
